keccak_round_ctrl: RTL and testbench

Sequences the Keccak-f[1600] permutation for the low-throughput SHA-3 core.
- Accepts a permutation request, pulses the state-load strobe, and steps one round per cycle.
- Drives the one-hot round index consumed by the round-constant generator.
- Holds the finished result until the downstream consumer accepts it.
- Sits between the padder/absorb logic and the round datapath; it is the only owner of the round index.

---
 rtl/keccak_round_ctrl.sv | 109 ++++++++++
 tb/tb_keccak_round_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - Keccak-f[1600] round sequencer: load strobe, one-hot round index, result hold
module keccak_round_ctrl #(
    parameter int ROUNDS = 24,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic             load_en,
    output logic             round_en,
    output logic [23:0]      round_oh,
    output logic [4:0]       round_idx,
    output logic             last_round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] perm_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_en) state_nxt = S_ROUND;
            end
            S_ROUND: begin
                if (last_round) state_nxt = S_DONE;
            end
            S_DONE: begin
                // A new request accepted during the handshake skips IDLE entirely.
                if (out_ready) state_nxt = in_valid ? S_ROUND : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        round_en   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_ROUND: begin
                round_en = ~stall;
                busy     = 1'b1;
            end
            S_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        load_en    = in_valid & in_ready;
        last_round = round_en & (round_idx == LAST_IDX);
    end

    // round_oh and round_idx move in lockstep; clearing on the last round keeps the constant generator at 0 in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_oh  <= '0;
            round_idx <= '0;
        end else if (load_en) begin
            round_oh  <= 24'h000001;
            round_idx <= 5'd0;
        end else if (last_round) begin
            round_oh  <= '0;
            round_idx <= '0;
        end else if (round_en) begin
            round_oh  <= round_oh << 1;
            round_idx <= round_idx + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perm_count <= '0;
        end else if (out_valid && out_ready) begin
            perm_count <= perm_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb/tb_keccak_round_ctrl.sv - scoreboard bench for keccak_round_ctrl
module tb_keccak_round_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_iv, a_ir, a_st, a_ld, a_re, a_lr, a_ov, a_or, a_busy;
    logic [23:0] a_oh;
    logic [4:0]  a_idx;
    logic [15:0] a_cnt;

    logic        b_iv, b_ir, b_st, b_ld, b_re, b_lr, b_ov, b_or, b_busy;
    logic [23:0] b_oh;
    logic [4:0]  b_idx;
    logic [15:0] b_cnt;

    logic        c_iv, c_ir, c_st, c_ld, c_re, c_lr, c_ov, c_or, c_busy;
    logic [23:0] c_oh;
    logic [4:0]  c_idx;
    logic [3:0]  c_cnt;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    keccak_round_ctrl #(.ROUNDS(24), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .stall(a_st),
        .load_en(a_ld), .round_en(a_re), .round_oh(a_oh), .round_idx(a_idx),
        .last_round(a_lr), .out_valid(a_ov), .out_ready(a_or), .busy(a_busy),
        .perm_count(a_cnt)
    );

    keccak_round_ctrl #(.ROUNDS(1), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .stall(b_st),
        .load_en(b_ld), .round_en(b_re), .round_oh(b_oh), .round_idx(b_idx),
        .last_round(b_lr), .out_valid(b_ov), .out_ready(b_or), .busy(b_busy),
        .perm_count(b_cnt)
    );

    keccak_round_ctrl #(.ROUNDS(24), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .in_valid(c_iv), .in_ready(c_ir), .stall(c_st),
        .load_en(c_ld), .round_en(c_re), .round_oh(c_oh), .round_idx(c_idx),
        .last_round(c_lr), .out_valid(c_ov), .out_ready(c_or), .busy(c_busy),
        .perm_count(c_cnt)
    );

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic push_perm(input int rounds);
        for (int k = 0; k < rounds; k++) exp_q.push_back(24'h1 << k);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        a_iv = 0; a_st = 0; a_or = 0;
        b_iv = 0; b_st = 0; b_or = 0;
        c_iv = 0; c_st = 0; c_or = 0;
        repeat (3) next_cyc;
        @(negedge clk);
        checks++;
        if ({a_oh, a_idx, a_ov, a_busy, a_ir, a_ld, a_re, a_lr} !== {24'h0, 5'h0, 6'b001000}) begin
            errors++;
            $display("FAIL reset_outputs got oh=%h idx=%0d ov=%b busy=%b ir=%b ld=%b re=%b lr=%b exp zeros with ir=1",
                     a_oh, a_idx, a_ov, a_busy, a_ir, a_ld, a_re, a_lr);
        end
        checks++;
        if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
        next_cyc;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ir, a_busy, b_ir, c_ir} !== 4'b1011) begin
            errors++;
            $display("FAIL reset_release got a_ir=%b a_busy=%b b_ir=%b c_ir=%b exp 1 0 1 1", a_ir, a_busy, b_ir, c_ir);
        end
        next_cyc;
    endtask

    task automatic test_basic;
        int re_cnt = 0;
        bit got_ov = 0;
        logic [23:0] e;
        a_iv = 1; a_or = 1;
        push_perm(24);
        @(negedge clk);
        checks++;
        if (a_ld !== 1'b1) begin errors++; $display("FAIL basic_load got %b exp 1", a_ld); end
        next_cyc;
        a_iv = 0;
        for (int cyc = 1; cyc <= 40 && !got_ov; cyc++) begin
            @(negedge clk);
            if (a_re) begin
                re_cnt++;
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL basic_extra_round got oh=%h exp no round", a_oh);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (a_oh !== e) begin errors++; $display("FAIL basic_oh got %h exp %h", a_oh, e); end
                    checks++;
                    if (a_idx !== 5'(re_cnt - 1)) begin errors++; $display("FAIL basic_idx got %0d exp %0d", a_idx, re_cnt - 1); end
                    checks++;
                    if (a_lr !== (e == 24'h800000)) begin errors++; $display("FAIL basic_last got %b exp %b", a_lr, e == 24'h800000); end
                end
            end
            if (a_ov) begin
                got_ov = 1;
                checks++;
                if (cyc != 25) begin errors++; $display("FAIL basic_latency got %0d exp 25", cyc); end
                checks++;
                if (a_oh !== 24'h0) begin errors++; $display("FAIL basic_done_oh got %h exp 0", a_oh); end
            end
            next_cyc;
        end
        checks++;
        if (!got_ov) begin errors++; $display("FAIL basic_out_valid got none exp one within 40 cycles"); end
        checks++;
        if (re_cnt != 24) begin errors++; $display("FAIL basic_round_count got %0d exp 24", re_cnt); end
        @(negedge clk);
        checks++;
        if ({a_cnt, a_busy, a_ov, a_ir} !== {16'd1, 3'b001}) begin
            errors++;
            $display("FAIL basic_after got cnt=%0d busy=%b ov=%b ir=%b exp 1 0 0 1", a_cnt, a_busy, a_ov, a_ir);
        end
        next_cyc;
    endtask

    task automatic test_stall;
        int re_cnt = 0;
        int phase = 0;
        bit got_ov = 0;
        logic [23:0] e;
        a_iv = 1; a_or = 1;
        push_perm(24);
        next_cyc;
        a_iv = 0;
        for (int cyc = 1; cyc <= 50 && !got_ov; cyc++) begin
            @(negedge clk);
            if (a_busy && !a_ov) phase++;
            checks++;
            if (a_re && a_ld) begin errors++; $display("FAIL stall_exclusive got ld=1 re=1 exp not both"); end
            if (a_st) begin
                checks++;
                if ({a_oh, a_re} !== {24'h000020, 1'b0}) begin
                    errors++;
                    $display("FAIL stall_hold got oh=%h re=%b exp 000020 0", a_oh, a_re);
                end
            end
            if (a_re) begin
                re_cnt++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (a_oh !== e) begin errors++; $display("FAIL stall_oh got %h exp %h", a_oh, e); end
                end
            end
            if (a_ov) got_ov = 1;
            next_cyc;
            a_st = (cyc + 1 >= 6) && (cyc + 1 <= 8);
        end
        a_st = 0;
        checks++;
        if (phase != 27) begin errors++; $display("FAIL stall_phase got %0d exp 27", phase); end
        checks++;
        if (re_cnt != 24) begin errors++; $display("FAIL stall_round_count got %0d exp 24", re_cnt); end
        checks++;
        if (a_cnt !== 16'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", a_cnt); end
    endtask

    task automatic test_backpressure;
        bit got_ov = 0;
        logic [15:0] cnt0;
        logic [23:0] e;
        a_iv = 1; a_or = 0;
        push_perm(24);
        next_cyc;
        a_iv = 0;
        for (int cyc = 1; cyc <= 40 && !got_ov; cyc++) begin
            @(negedge clk);
            if (a_re && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (a_oh !== e) begin errors++; $display("FAIL bp_oh got %h exp %h", a_oh, e); end
            end
            if (a_ov) got_ov = 1;
            else next_cyc;
        end
        cnt0 = a_cnt;
        next_cyc;
        a_iv = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({a_ov, a_ir, a_ld} !== 3'b100) begin
                errors++;
                $display("FAIL bp_hold got ov=%b ir=%b ld=%b exp 1 0 0", a_ov, a_ir, a_ld);
            end
            next_cyc;
        end
        a_or = 1;
        push_perm(24);
        @(negedge clk);
        checks++;
        if ({a_ov, a_ld} !== 2'b11) begin errors++; $display("FAIL bp_handshake got ov=%b ld=%b exp 1 1", a_ov, a_ld); end
        next_cyc;
        a_iv = 0;
        got_ov = 0;
        for (int cyc = 1; cyc <= 40 && !got_ov; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if ({a_oh, a_busy, a_ov, a_cnt} !== {24'h1, 2'b10, cnt0 + 16'd1}) begin
                    errors++;
                    $display("FAIL bp_b2b got oh=%h busy=%b ov=%b cnt=%0d exp 1 1 0 %0d", a_oh, a_busy, a_ov, a_cnt, cnt0 + 16'd1);
                end
            end
            if (a_re && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (a_oh !== e) begin errors++; $display("FAIL bp_oh2 got %h exp %h", a_oh, e); end
            end
            if (a_ov) got_ov = 1;
            next_cyc;
        end
        checks++;
        if (!got_ov || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got ov=%b left=%0d exp 1 0", got_ov, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit hit = 0;
        int ov_seen = 0;
        a_iv = 1; a_or = 1;
        next_cyc;
        a_iv = 0;
        for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
            @(negedge clk);
            if (a_re && a_idx == 5'd12) hit = 1;
            else next_cyc;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_reach got no idx 12 exp idx 12 within 40 cycles"); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({a_oh, a_idx, a_ov, a_busy, a_ir, a_ld, a_re, a_lr, a_cnt} !== {24'h0, 5'h0, 6'b001000, 16'd0}) begin
            errors++;
            $display("FAIL mid_async got oh=%h idx=%0d ov=%b busy=%b ir=%b re=%b cnt=%0d exp reset values",
                     a_oh, a_idx, a_ov, a_busy, a_ir, a_re, a_cnt);
        end
        exp_q.delete();
        next_cyc;
        next_cyc;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_ov) ov_seen++;
            next_cyc;
        end
        checks++;
        if ({ov_seen != 0, a_ir, a_busy} !== 3'b010) begin
            errors++;
            $display("FAIL mid_after got ov_seen=%0d ir=%b busy=%b exp 0 1 0", ov_seen, a_ir, a_busy);
        end
    endtask

    task automatic test_rounds1;
        logic [23:0] e;
        b_iv = 1; b_or = 1;
        push_perm(1);
        @(negedge clk);
        checks++;
        if (b_ld !== 1'b1) begin errors++; $display("FAIL r1_load got %b exp 1", b_ld); end
        next_cyc;
        b_iv = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({b_re, b_oh, b_idx, b_lr, b_ov} !== {1'b1, e, 5'd0, 2'b10}) begin
            errors++;
            $display("FAIL r1_round got re=%b oh=%h idx=%0d lr=%b ov=%b exp 1 %h 0 1 0", b_re, b_oh, b_idx, b_lr, b_ov, e);
        end
        next_cyc;
        @(negedge clk);
        checks++;
        if ({b_ov, b_re, b_oh} !== {2'b10, 24'h0}) begin
            errors++;
            $display("FAIL r1_done got ov=%b re=%b oh=%h exp 1 0 0", b_ov, b_re, b_oh);
        end
        next_cyc;
        @(negedge clk);
        checks++;
        if ({b_cnt, b_busy} !== {16'd1, 1'b0}) begin
            errors++;
            $display("FAIL r1_count got cnt=%0d busy=%b exp 1 0", b_cnt, b_busy);
        end
        next_cyc;
    endtask

    task automatic test_back_to_back;
        int hs = 0;
        int idle = 0;
        logic [23:0] e;
        c_iv = 1; c_or = 1;
        for (int cyc = 0; cyc < 700 && hs < 17; cyc++) begin
            @(negedge clk);
            if (c_ld) push_perm(24);
            if (c_re) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL b2b_extra_round got oh=%h exp no round", c_oh);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (c_oh !== e) begin errors++; $display("FAIL b2b_oh got %h exp %h", c_oh, e); end
                end
            end
            if (cyc > 0 && !c_busy) idle++;
            if (c_ov) begin
                hs++;
                if (hs < 17) begin
                    checks++;
                    if (c_ld !== 1'b1) begin errors++; $display("FAIL b2b_reload got %b exp 1 at handshake %0d", c_ld, hs); end
                end
            end
            next_cyc;
            if (hs >= 16) c_iv = 0;
        end
        checks++;
        if (hs != 17) begin errors++; $display("FAIL b2b_handshakes got %0d exp 17", hs); end
        checks++;
        if (idle != 0) begin errors++; $display("FAIL b2b_idle got %0d exp 0", idle); end
        @(negedge clk);
        checks++;
        if ({c_cnt, c_busy, exp_q.size() == 0} !== {4'd1, 2'b01}) begin
            errors++;
            $display("FAIL b2b_wrap got cnt=%0d busy=%b left=%0d exp 1 0 0", c_cnt, c_busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_backpressure;
        test_reset_mid;
        test_rounds1;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
